// File: rtl/fpcvt_serializer_if.sv
// Converter-to-serializer word handshake: sign/exponent/significand triple with valid/ready.
// The converter drives the master side; the serializer consumes it on the slave side.
interface fpcvt_serializer_if;
    logic       s_in;
    logic [2:0] e_in;
    logic [3:0] f_in;
    logic       in_valid;
    logic       in_ready;

    modport master (output s_in, e_in, f_in, in_valid, input in_ready);
    modport slave  (input s_in, e_in, f_in, in_valid, output in_ready);
endinterface

// File: rtl/fpcvt_serializer.sv
// FIFO-buffered UART-style serializer for {s, e[2:0], f[3:0]} words, MSB first, idle-high line.
// Define FPCVT_SER_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fpcvt_serializer #(
    parameter int BIT_CYCLES = 4,
    parameter int DEPTH      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    fpcvt_serializer_if.slave            in_if,
    output logic                         ser_out,
    output logic                         busy,
    output logic                         frame_done,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef FPCVT_SER_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [2:0]    state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [2:0]    nxt_pos;
    logic [7:0]    shreg;
    logic          push, pop, bit_end, fifo_nempty;

    // Ready looks only at the registered level, so a same-cycle pop never frees a slot early.
    assign in_if.in_ready = (fifo_level < LVL_FULL);
    assign push        = in_if.in_valid && in_if.in_ready;
    assign fifo_nempty = (fifo_level != '0);
    assign bit_end     = (bit_cnt == CNT_LAST);
    assign pop         = fifo_nempty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
    assign busy        = (state != S_IDLE);
    assign frame_done  = (state == S_STOP) && bit_end;
    assign nxt_pos     = 3'd6 - bit_idx;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_if.s_in, in_if.e_in, in_if.f_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      fifo_level <= fifo_level + LW'(1);
            else if (pop && !push) fifo_level <= fifo_level - LW'(1);
        end
    end

    // ser_out is loaded with the value of the bit about to be held, so it changes with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            ser_out <= 1'b1;
        end else begin
            bit_cnt <= ((state == S_IDLE) || bit_end) ? '0 : bit_cnt + CW'(1);
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state   <= S_START;
                        shreg   <= mem[rd_ptr];
                        ser_out <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                        ser_out <= shreg[7];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef FPCVT_SER_PARITY_EN
                            state   <= S_PARITY;
                            ser_out <= ^shreg;
`else
                            state   <= S_STOP;
                            ser_out <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            ser_out <= shreg[nxt_pos];
                        end
                    end
                end
`ifdef FPCVT_SER_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state   <= S_STOP;
                        ser_out <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            state   <= S_START;
                            shreg   <= mem[rd_ptr];
                            ser_out <= 1'b0;
                        end else begin
                            state   <= S_IDLE;
                            ser_out <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ser_out <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpcvt_serializer.sv
// Bench for fpcvt_serializer: a per-clock line-level model (FIFO queue + queue of expected
// line values) checked every cycle, plus hand-computed literal expectations for directed cases.
module tb_fpcvt_serializer;
    localparam int BC    = 2;
    localparam int DEPTH = 2;
`ifdef FPCVT_SER_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_out, busy, frame_done;
    logic [1:0] fifo_level;

    fpcvt_serializer_if bus();

    fpcvt_serializer #(.BIT_CYCLES(BC), .DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_if      (bus.slave),
        .ser_out    (ser_out),
        .busy       (busy),
        .frame_done (frame_done),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [7:0] m_fifo[$];
    bit         m_line[$];
    bit         m_push;
    logic [7:0] m_word;

    function automatic bit frame_bit(input logic [7:0] w, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return w[8-b];
        if (b == FB - 1) return 1'b1;
        return ^w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            m_line.delete();
        end else begin
            m_push = bus.in_valid && (m_fifo.size() < DEPTH);
            if (m_line.size() != 0) void'(m_line.pop_front());
            if (m_line.size() == 0 && m_fifo.size() != 0) begin
                m_word = m_fifo.pop_front();
                for (int b = 0; b < FB; b++)
                    for (int c = 0; c < BC; c++) m_line.push_back(frame_bit(m_word, b));
            end
            if (m_push) m_fifo.push_back({bus.s_in, bus.e_in, bus.f_in});
        end
    end

    always @(negedge clk) begin
        check("ser_out",    ser_out,    (m_line.size() != 0) ? 32'(m_line[0]) : 32'd1);
        check("busy",       busy,       32'(m_line.size() != 0));
        check("frame_done", frame_done, 32'(m_line.size() == 1));
        check("fifo_level", fifo_level, 32'(m_fifo.size()));
        check("in_ready",   bus.in_ready, 32'(m_fifo.size() < DEPTH));
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [7:0] w, output int waited);
        bit ok;
        waited = 0;
        {bus.s_in, bus.e_in, bus.f_in} = w;
        bus.in_valid = 1'b1;
        while (1) begin
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            waited++;
            if (waited > 500) begin
                check("push_timeout", 0, 1);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_fd(input string nm);
        int n = 0;
        @(negedge clk);
        while (!frame_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(nm, frame_done, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || fifo_level != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_idle", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    logic [10:0] frame_da;
    int          w8;

    initial begin
        bus.in_valid = 1'b0;
        bus.s_in = 1'b0; bus.e_in = '0; bus.f_in = '0;
`ifdef FPCVT_SER_PARITY_EN
        frame_da = 11'b01101101011;
`else
        frame_da = 11'b00110110101;
`endif
        repeat (3) @(posedge clk);
        #2;
        check("rst_ser_out", ser_out, 1);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;

        // Single frame of 0xDA, each bit held BC clocks.
        @(posedge clk); #1;
        push(8'hDA, w8);
        @(posedge clk);
        for (int i = 0; i < FB * BC; i++) begin
            @(negedge clk);
            check("single_bit", ser_out, 32'(frame_da[FB - 1 - i / BC]));
            check("single_fd", frame_done, 32'(i == FB * BC - 1));
        end
        @(negedge clk);
        check("single_busy_after", busy, 0);
        check("single_line_idle", ser_out, 1);

        // Back-to-back frames, no idle gap.
        @(posedge clk); #1;
        push(8'hDA, w8);
        check("b2b_level0", fifo_level, 1);
        push(8'h05, w8);
        check("b2b_level1", fifo_level, 1);
        wait_fd("b2b_fd1");
        check("b2b_stop_high", ser_out, 1);
        @(negedge clk);
        check("b2b_start_low", ser_out, 0);
        check("b2b_level2", fifo_level, 0);
        drain();

        // Full FIFO: fourth word waits for the first pop after A's frame.
        @(posedge clk); #1;
        push(8'h11, w8);
        push(8'h22, w8);
        push(8'h33, w8);
        check("full_level", fifo_level, 2);
        check("full_ready", bus.in_ready, 0);
        push(8'h44, w8);
        check("full_wait", w8, FB * BC - 1);
        check("full_level_after", fifo_level, 2);
        drain();

        // Push coinciding with the STOP->START pop, level 1.
        @(posedge clk); #1;
        push(8'h5A, w8);
        push(8'hA5, w8);
        wait_fd("sim_fd");
        {bus.s_in, bus.e_in, bus.f_in} = 8'h3C;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("sim_level", fifo_level, 1);
        check("sim_start", ser_out, 0);
        drain();

        // Reset mid-frame with a word queued; pushes during reset are ignored.
        @(posedge clk); #1;
        push(8'h81, w8);
        push(8'h7E, w8);
        repeat (6) @(negedge clk);
        check("pre_rst_low", ser_out, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ser", ser_out, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_level", fifo_level, 0);
        {bus.s_in, bus.e_in, bus.f_in} = 8'hC3;
        bus.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        #1 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_level", fifo_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
